// File: rtl/not16_checker_pkg.sv
// not16_checker shared types and constants.
// Default widths, FSM states and counter ceiling.
package not16_chk_pkg;

  localparam int WIDTH_D = 16;
  localparam int CNT_W_D = 16;

  localparam logic [CNT_W_D-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/not16_checker_if.sv
// Vector-pair handshake between the DUT harness and the checker.
// master = harness side, slave = checker side.
interface not16_checker_if #(
  parameter int WIDTH = 16
);

  logic             vec_valid;
  logic             vec_ready;
  logic [WIDTH-1:0] vec_a;
  logic [WIDTH-1:0] vec_out;
  logic             vec_last;

  modport master (
    output vec_valid,
    output vec_a,
    output vec_out,
    output vec_last,
    input  vec_ready
  );

  modport slave (
    input  vec_valid,
    input  vec_a,
    input  vec_out,
    input  vec_last,
    output vec_ready
  );

endinterface

// File: rtl/not16_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_q
);

  logic [CNT_W-1:0] r_q;

  // count up on i_inc, stop at the ceiling
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/not16_checker.sv
// Checks DUT pairs against out == ~a over a valid/ready link.
// Option: NOT16_CHK_HALT_ON_ERR_EN stops the run at the first mismatch.
module not16_checker
  import not16_chk_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  not16_checker_if.slave   vec,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_vec_count,
  output logic [CNT_W-1:0] o_err_count,
  output logic [WIDTH-1:0] o_err_bits,
  output logic [CNT_W-1:0] o_first_fail_idx,
  output logic [WIDTH-1:0] o_first_fail_a,
  output logic [WIDTH-1:0] o_first_fail_out
);

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_s1_vld;
  logic             r_s1_last;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_out;

  logic             r_last_acc;
  logic             r_found;
  logic             r_pass;
  logic [WIDTH-1:0] r_err_bits;
  logic [CNT_W-1:0] r_ff_idx;
  logic [WIDTH-1:0] r_ff_a;
  logic [WIDTH-1:0] r_ff_out;

  logic             w_ready;
  logic             w_busy;
  logic             w_done;
  logic             w_accept;
  logic             w_go;
  logic [WIDTH-1:0] w_diff;
  logic             w_mis;
  logic             w_halt;
  logic             w_fin;
  logic [CNT_W-1:0] w_vec_q;
  logic [CNT_W-1:0] w_err_q;

  assign w_go     = i_start && (r_state != S_RUN);
  assign w_accept = vec.vec_valid && w_ready;
  assign w_diff   = r_s1_out ^ ~r_s1_a;
  assign w_mis    = r_s1_vld && (w_diff != '0);

`ifdef NOT16_CHK_HALT_ON_ERR_EN
  assign w_halt = w_mis && !r_found;
`else
  assign w_halt = 1'b0;
`endif

  assign w_fin = (r_s1_vld && r_s1_last) || w_halt;

  // state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_fin)   w_state_nxt = S_DONE;
      S_DONE:  if (i_start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    w_busy  = (r_state == S_RUN);
    w_done  = (r_state == S_DONE);
    w_ready = (r_state == S_RUN) && !r_last_acc;
  end

  // stage 1: capture the accepted pair
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_a    <= '0;
      r_s1_out  <= '0;
    end else begin
      r_s1_vld <= w_accept && !w_halt;
      if (w_accept) begin
        r_s1_last <= vec.vec_last;
        r_s1_a    <= vec.vec_a;
        r_s1_out  <= vec.vec_out;
      end
    end
  end

  // remember that the final pair has been taken
  always_ff @(posedge i_clk) begin
    if (i_reset || w_go) begin
      r_last_acc <= 1'b0;
    end else if (w_accept && vec.vec_last) begin
      r_last_acc <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_vec_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_go),
    .i_inc   (r_s1_vld),
    .o_q     (w_vec_q)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_go),
    .i_inc   (w_mis),
    .o_q     (w_err_q)
  );

  // stage 2: accumulate diff bits and latch first failure
  always_ff @(posedge i_clk) begin
    if (i_reset || w_go) begin
      r_err_bits <= '0;
      r_found    <= 1'b0;
      r_ff_idx   <= '0;
      r_ff_a     <= '0;
      r_ff_out   <= '0;
    end else if (r_s1_vld) begin
      r_err_bits <= r_err_bits | w_diff;
      if (w_mis && !r_found) begin
        r_found  <= 1'b1;
        r_ff_idx <= w_vec_q;
        r_ff_a   <= r_s1_a;
        r_ff_out <= r_s1_out;
      end
    end
  end

  // pass is settled on the edge that enters DONE
  always_ff @(posedge i_clk) begin
    if (i_reset || w_go) begin
      r_pass <= 1'b0;
    end else if (w_busy && w_fin) begin
      r_pass <= (w_err_q == '0) && !w_mis;
    end
  end

  assign vec.vec_ready    = w_ready;
  assign o_busy           = w_busy;
  assign o_done           = w_done;
  assign o_pass           = r_pass;
  assign o_vec_count      = w_vec_q;
  assign o_err_count      = w_err_q;
  assign o_err_bits       = r_err_bits;
  assign o_first_fail_idx = r_ff_idx;
  assign o_first_fail_a   = r_ff_a;
  assign o_first_fail_out = r_ff_out;

endmodule

// File: tb/tb_not16_checker.sv
// Scoreboard bench for not16_checker (16-bit and CNT_W=2 instances).
// Expected run results are queued at start; monitors pop on done.
module tb_not16_checker;

  typedef struct {
    logic [15:0] vc;
    logic [15:0] ec;
    logic [15:0] eb;
    logic [15:0] idx;
    logic [15:0] fa;
    logic [15:0] fo;
    logic        pass;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        valid;
  logic        last;
  logic        sel;
  logic [15:0] a;
  logic [15:0] o;

  always #5 clk = ~clk;

  not16_checker_if #(.WIDTH(16)) if0 ();
  not16_checker_if #(.WIDTH(16)) if1 ();

  assign if0.vec_valid = valid & ~sel;
  assign if0.vec_a     = a;
  assign if0.vec_out   = o;
  assign if0.vec_last  = last;
  assign if1.vec_valid = valid & sel;
  assign if1.vec_a     = a;
  assign if1.vec_out   = o;
  assign if1.vec_last  = last;

  wire ready = sel ? if1.vec_ready : if0.vec_ready;

  logic        d0_busy, d0_done, d0_pass;
  logic [15:0] d0_vc, d0_ec, d0_eb, d0_idx, d0_fa, d0_fo;
  logic        d1_busy, d1_done, d1_pass;
  logic [1:0]  d1_vc, d1_ec, d1_idx;
  logic [15:0] d1_eb, d1_fa, d1_fo;

  not16_checker #(.WIDTH(16), .CNT_W(16)) u_dut0 (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_start          (start & ~sel),
    .vec              (if0),
    .o_busy           (d0_busy),
    .o_done           (d0_done),
    .o_pass           (d0_pass),
    .o_vec_count      (d0_vc),
    .o_err_count      (d0_ec),
    .o_err_bits       (d0_eb),
    .o_first_fail_idx (d0_idx),
    .o_first_fail_a   (d0_fa),
    .o_first_fail_out (d0_fo)
  );

  not16_checker #(.WIDTH(16), .CNT_W(2)) u_dut1 (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_start          (start & sel),
    .vec              (if1),
    .o_busy           (d1_busy),
    .o_done           (d1_done),
    .o_pass           (d1_pass),
    .o_vec_count      (d1_vc),
    .o_err_count      (d1_ec),
    .o_err_bits       (d1_eb),
    .o_first_fail_idx (d1_idx),
    .o_first_fail_a   (d1_fa),
    .o_first_fail_out (d1_fo)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  bit   p0 = 1'b0;
  bit   p1 = 1'b0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic exp_t mk(logic [15:0] vc, ec, eb, idx, fa, fo,
                              logic pass);
    exp_t e;
    e.vc = vc; e.ec = ec; e.eb = eb; e.idx = idx;
    e.fa = fa; e.fo = fo; e.pass = pass;
    return e;
  endfunction

  // monitors: compare each run's results when done rises
  always @(negedge clk) begin
    if (d0_done && !p0) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_done", 32'd1, 32'd0);
      end else begin
        e0 = q0.pop_front();
        chk("dut0_vec_count", {16'd0, d0_vc}, {16'd0, e0.vc});
        chk("dut0_err_count", {16'd0, d0_ec}, {16'd0, e0.ec});
        chk("dut0_err_bits", {16'd0, d0_eb}, {16'd0, e0.eb});
        chk("dut0_ff_idx", {16'd0, d0_idx}, {16'd0, e0.idx});
        chk("dut0_ff_a", {16'd0, d0_fa}, {16'd0, e0.fa});
        chk("dut0_ff_out", {16'd0, d0_fo}, {16'd0, e0.fo});
        chk("dut0_pass", {31'd0, d0_pass}, {31'd0, e0.pass});
        chk("dut0_busy_in_done", {31'd0, d0_busy}, 32'd0);
      end
    end
    if (d1_done && !p1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_vec_count", {30'd0, d1_vc}, {16'd0, e1.vc});
        chk("dut1_err_count", {30'd0, d1_ec}, {16'd0, e1.ec});
        chk("dut1_err_bits", {16'd0, d1_eb}, {16'd0, e1.eb});
        chk("dut1_ff_idx", {30'd0, d1_idx}, {16'd0, e1.idx});
        chk("dut1_ff_a", {16'd0, d1_fa}, {16'd0, e1.fa});
        chk("dut1_ff_out", {16'd0, d1_fo}, {16'd0, e1.fo});
        chk("dut1_pass", {31'd0, d1_pass}, {31'd0, e1.pass});
      end
    end
    p0 = d0_done;
    p1 = d1_done;
  end

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] av, input logic [15:0] ov,
                      input logic lv, output bit ok);
    ok    = 1'b0;
    valid = 1'b1;
    a     = av;
    o     = ov;
    last  = lv;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (ready) ok = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic idle();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic wait_done(input bit s, input string n);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      if (s ? d1_done : d0_done) seen = 1'b1;
      else @(negedge clk);
    end
    chk(n, {31'd0, seen}, 32'd1);
  endtask

  bit ok;

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0;
    sel = 1'b0; a = '0; o = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_busy", {31'd0, d0_busy}, 32'd0);
    chk("rst_done", {31'd0, d0_done}, 32'd0);
    chk("rst_pass", {31'd0, d0_pass}, 32'd0);
    chk("rst_vc", {16'd0, d0_vc}, 32'd0);
    chk("rst_ec", {16'd0, d0_ec}, 32'd0);
    chk("rst_eb", {16'd0, d0_eb}, 32'd0);
    chk("rst_ready", {31'd0, if0.vec_ready}, 32'd0);
    chk("rst_dut1_vc", {30'd0, d1_vc}, 32'd0);

    // stray bad pair while idle must be ignored
    valid = 1'b1; a = 16'h0000; o = 16'h0000; last = 1'b1;
    @(negedge clk);
    idle();
    chk("idle_busy", {31'd0, d0_busy}, 32'd0);

    // run 1: four good pairs back to back
    q0.push_back(mk(4, 0, 16'h0000, 0, 0, 0, 1'b1));
    start_run();
    send(16'h0000, 16'hFFFF, 1'b0, ok); chk("t1_acc0", {31'd0, ok}, 1);
    send(16'hFFFF, 16'h0000, 1'b0, ok); chk("t1_acc1", {31'd0, ok}, 1);
    send(16'hAAAA, 16'h5555, 1'b0, ok); chk("t1_acc2", {31'd0, ok}, 1);
    send(16'h5555, 16'hAAAA, 1'b1, ok); chk("t1_acc3", {31'd0, ok}, 1);
    idle();
    chk("t1_done_early", {31'd0, d0_done}, 32'd0);
    chk("t1_ready_after_last", {31'd0, if0.vec_ready}, 32'd0);
    wait_done(1'b0, "t1_done_timeout");

    // run 2: two mismatches
`ifdef NOT16_CHK_HALT_ON_ERR_EN
    q0.push_back(mk(2, 1, 16'h0001, 1, 16'h00F0, 16'hFF0E, 1'b0));
`else
    q0.push_back(mk(3, 2, 16'h0001, 1, 16'h00F0, 16'hFF0E, 1'b0));
`endif
    start_run();
    send(16'h0000, 16'hFFFF, 1'b0, ok);
    send(16'h00F0, 16'hFF0E, 1'b0, ok);
    send(16'h1234, 16'hEDCA, 1'b1, ok);
    idle();
    wait_done(1'b0, "t2_done_timeout");

    // run 3: valid toggling every other cycle
    q0.push_back(mk(4, 0, 16'h0000, 0, 0, 0, 1'b1));
    start_run();
    send(16'h0F0F, 16'hF0F0, 1'b0, ok); idle(); @(negedge clk);
    send(16'h1234, 16'hEDCB, 1'b0, ok); idle(); @(negedge clk);
    send(16'h8000, 16'h7FFF, 1'b0, ok); idle(); @(negedge clk);
    send(16'hFFFE, 16'h0001, 1'b1, ok); idle();
    chk("t3_ready_after_last", {31'd0, if0.vec_ready}, 32'd0);
    wait_done(1'b0, "t3_done_timeout");

    // run 4: reset two pairs into a five-pair run
    start_run();
    send(16'h1111, 16'hEEEE, 1'b0, ok);
    send(16'h2222, 16'hDDDD, 1'b0, ok);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_busy", {31'd0, d0_busy}, 32'd0);
    chk("t4_done", {31'd0, d0_done}, 32'd0);
    chk("t4_pass", {31'd0, d0_pass}, 32'd0);
    chk("t4_vc", {16'd0, d0_vc}, 32'd0);
    chk("t4_ec", {16'd0, d0_ec}, 32'd0);
    chk("t4_ready", {31'd0, if0.vec_ready}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t4_vc_late", {16'd0, d0_vc}, 32'd0);
    q0.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 1'b1));
    start_run();
    send(16'hFFFF, 16'h0000, 1'b1, ok);
    idle();
    wait_done(1'b0, "t4_done_timeout");

    // run 5: single bad pair mid-run
`ifdef NOT16_CHK_HALT_ON_ERR_EN
    q0.push_back(mk(2, 1, 16'hFFFE, 1, 16'h0001, 16'h0000, 1'b0));
`else
    q0.push_back(mk(3, 1, 16'hFFFE, 1, 16'h0001, 16'h0000, 1'b0));
`endif
    start_run();
    send(16'h0000, 16'hFFFF, 1'b0, ok);
    send(16'h0001, 16'h0000, 1'b0, ok);
    send(16'h0002, 16'hFFFD, 1'b1, ok);
`ifndef NOT16_CHK_HALT_ON_ERR_EN
    chk("t5_acc2", {31'd0, ok}, 1);
`endif
    idle();
    wait_done(1'b0, "t5_done_timeout");

    // run 6: CNT_W=2 instance, five bad pairs
    sel = 1'b1;
    @(negedge clk);
`ifdef NOT16_CHK_HALT_ON_ERR_EN
    q1.push_back(mk(1, 1, 16'hFFFF, 0, 16'h0000, 16'h0000, 1'b0));
`else
    q1.push_back(mk(3, 3, 16'hFFFF, 0, 16'h0000, 16'h0000, 1'b0));
`endif
    start_run();
    send(16'h0000, 16'h0000, 1'b0, ok);
    send(16'h1111, 16'h1111, 1'b0, ok);
    send(16'hFFFF, 16'hFFFF, 1'b0, ok);
    send(16'h0F0F, 16'h0F0F, 1'b0, ok);
    send(16'h1234, 16'h1234, 1'b1, ok);
    idle();
    wait_done(1'b1, "t6_done_timeout");

    for (int k = 0; k < 10 && (q0.size() + q1.size()) != 0; k++)
      @(negedge clk);
    chk("sb_drained", q0.size() + q1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/not16_checker.md
Name: not16_checker

Overview:
- Response-side companion to the 16-bit NOT stimulus path: it consumes (a, out) vector pairs from a DUT harness over a valid/ready handshake and checks each pair against out == ~a.
- Counts vectors and mismatches, captures the first failing vector, and reports pass/done.
- Sits after the DUT in the on-FPGA self-test harness and lets the project-1 gates be verified in hardware without a simulator.

Parameters:
- WIDTH, 16, data width of a/out.
- CNT_W, 16, width of the vector and error counters; both saturate.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; clears all results and begins a run. Honoured in IDLE or DONE, ignored in RUN.
- vec_valid  in  1  input vector pair valid.
- vec_ready  out  1  checker can accept a pair.
- vec_a  in  WIDTH  stimulus applied to the DUT.
- vec_out  in  WIDTH  DUT response.
- vec_last  in  1  marks the final pair of the run.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid when done; 1 iff err_count == 0.
- vec_count  out  CNT_W  pairs checked.
- err_count  out  CNT_W  mismatching pairs.
- err_bits  out  WIDTH  OR-accumulation of (vec_out ^ ~vec_a) over the run.
- first_fail_idx  out  CNT_W  index of the first mismatching pair (0-based).
- first_fail_a  out  WIDTH  vec_a of the first mismatching pair.
- first_fail_out  out  WIDTH  vec_out of the first mismatching pair.

Behaviour:
- Reset (synchronous, active-high, wins over every other input) sets:
  - state = IDLE
  - vec_ready, busy, done, pass = 0
  - all counters, err_bits and first_fail_* = 0
  - stage-1 valid = 0
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: leaves only when the last pair has been checked.
  - DONE: start -> RUN.
- start clears counters, err_bits, first_fail_* and the found flag in the same edge that enters RUN.
- Acceptance:
  - vec_ready = 1 in RUN while no last pair has been accepted yet.
  - A pair transfers on any edge where vec_valid && vec_ready.
  - vec_valid outside RUN is ignored; nothing is captured.
- Pipeline (two stages):
  - The accepted pair and last flag are registered into stage 1.
  - On the next edge, compare (s1_out != ~s1_a) and update:
    - vec_count += 1
    - on mismatch, err_count += 1
    - err_bits |= diff
    - first_fail_* written only if no earlier failure was recorded.
- Latency:
  - Counters reflect a pair 2 edges after its acceptance edge.
  - done/pass assert on the same edge that the last pair's counters update.
  - Back-to-back acceptance at 1 pair/cycle.
- Last pair:
  - vec_ready drops the cycle after a pair with vec_last=1 is accepted.
  - State goes RUN -> DONE when stage 1 holds the last pair and it is checked.
  - A run of a single pair with last=1 is legal.
- pass = (err_count == 0), registered; it is set on the DONE entry edge and includes the final pair.
- Saturation: counters stop at 2^CNT_W-1, and err_count keeps tracking even when vec_count saturates.
- Index: first_fail_idx equals the value of vec_count before the increment for that pair.
- start while in RUN: ignored, with no clearing.
- Reset mid-run: discards stage 1 and all results; the checker returns to IDLE.
- Results hold stable in DONE until the next start or reset.

Optional Feature:
- Macro NOT16_CHK_HALT_ON_ERR_EN.
- Defined:
  - On the edge recording the first mismatch, state -> DONE, pass = 0.
  - vec_ready deasserts from that edge.
  - A pair accepted on that same edge is discarded and not counted.
- Undefined: the run always continues to the last pair.

Decomposition:
- Package not16_chk_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - default WIDTH = 16 and CNT_W = 16
  - CNT_MAX constant
- One natural sub-module, sat_counter (CNT_W wide, clear/increment, saturating), used for both vec_count and err_count.

Test Plan:
1. reset, start, then 4 pairs with vec_valid held high: (0000,FFFF), (FFFF,0000), (AAAA,5555), (5555,AAAA last) -> end state:
   - done=1, pass=1, vec_count=4, err_count=0, err_bits=0000
   - done 2 cycles after the last acceptance.
2. start, then 3 pairs: (0000,FFFF), (00F0,FF0E), (1234,EDCA last) -> end state:
   - err_count=2, err_bits=0001|0001=0001
   - first_fail_idx=1, first_fail_a=00F0, first_fail_out=FF0E, pass=0.
3. vec_valid toggling every other cycle, plus a vec_valid pulse while in IDLE -> IDLE pulse not counted; final vec_count equals the handshakes seen in RUN; vec_ready=0 after last.
4. Reset asserted mid-run after 2 of 5 pairs -> next cycle: all outputs 0, state IDLE. A new start plus 1 pair (FFFF,0000 last) gives vec_count=1, pass=1.
5. With NOT16_CHK_HALT_ON_ERR_EN: pairs (0000,FFFF), (0001,0000), (0002,FFFD) -> done after the 2nd pair is checked, vec_count=2, err_count=1, 3rd pair never accepted. Without the macro: vec_count=3, err_count=1.
6. CNT_W=2, 5 pairs all bad -> vec_count=3, err_count=3 (saturated), first_fail_idx=0, done=1.
